// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit single-cycle CPU: opcodes, instruction
// field positions and the instruction loader state encoding.
package cpu16_pkg;

    localparam int INSTR_W = 16;

    // Legal opcode set; 0011 through 1000 are unassigned.
    localparam logic [3:0] OP_LOGIC = 4'b0000;
    localparam logic [3:0] OP_ARITH = 4'b0001;
    localparam logic [3:0] OP_SHIFT = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_SUBI  = 4'b1010;
    localparam logic [3:0] OP_SLTI  = 4'b1011;
    localparam logic [3:0] OP_LW    = 4'b1100;
    localparam logic [3:0] OP_SW    = 4'b1101;
    localparam logic [3:0] OP_BNE   = 4'b1110;
    localparam logic [3:0] OP_BEQ   = 4'b1111;

    // Least-significant bit of each field within the instruction word.
    localparam int OP_LSB    = 12;
    localparam int RS_LSB    = 10;
    localparam int RT_LSB    = 8;
    localparam int RD_LSB    = 6;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE
    } loaderState_e;

endpackage

// File: rtl/instr_loader_if.sv
// Decoded instruction field stream: the source drives a field bundle under
// valid/ready, the loader consumes it.
interface instr_loader_if;

    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [1:0] in_rs;
    logic [1:0] in_rt;
    logic [1:0] in_rd;
    logic [1:0] in_funct;
    logic [7:0] in_imm;
    logic       in_last;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_last,
        output in_ready
    );

endinterface

// File: rtl/instr_encode.sv
// Combinational field-to-word encoder with legal-opcode flag; shared with the
// disassembler checker.
module instr_encode
    import cpu16_pkg::*;
(
    input  logic [3:0]         op,
    input  logic [1:0]         rs,
    input  logic [1:0]         rt,
    input  logic [1:0]         rd,
    input  logic [1:0]         funct,
    input  logic [7:0]         imm,
    output logic [INSTR_W-1:0] word,
    output logic               legal
);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (op)
            OP_LOGIC, OP_ARITH, OP_SHIFT: begin
                word  = {op, rs, rt, rd, 4'b0000, funct};
                legal = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_SLTI, OP_LW, OP_SW, OP_BNE, OP_BEQ: begin
                word  = {op, rs, rt, imm};
                legal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Sequential instruction loader: encodes field bundles and writes them into
// instruction memory at consecutive addresses, one word per two cycles.
module instr_loader
    import cpu16_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    instr_loader_if.slave       fieldIf,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [INSTR_W-1:0]  imem_wdata,
    output logic [ADDR_W:0]     count,
    output logic                done,
    output logic                err_illegal,
    output logic                err_full
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    loaderState_e       stateQ, stateD;
    logic               lastQ;
    logic [INSTR_W-1:0] encWord;
    logic               encLegal;
    logic               handshake;
    logic               clearSession;
    logic               acceptWord;
    logic               setIllegal;
    logic               setFull;

    instr_encode u_encode (
        .op    (fieldIf.in_op),
        .rs    (fieldIf.in_rs),
        .rt    (fieldIf.in_rt),
        .rd    (fieldIf.in_rd),
        .funct (fieldIf.in_funct),
        .imm   (fieldIf.in_imm),
        .word  (encWord),
        .legal (encLegal)
    );

    assign fieldIf.in_ready = (stateQ == ST_ACCEPT);
    assign handshake        = fieldIf.in_valid && fieldIf.in_ready;

    always_comb begin
        stateD       = stateQ;
        clearSession = 1'b0;
        acceptWord   = 1'b0;
        setIllegal   = 1'b0;
        setFull      = 1'b0;
        case (stateQ)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    stateD       = ST_ACCEPT;
                    clearSession = 1'b1;
                end
            end
            ST_ACCEPT: begin
                if (handshake) begin
                    if (encLegal) begin
                        stateD     = ST_WRITE;
                        acceptWord = 1'b1;
                    end else begin
                        // Illegal bundles are dropped without consuming an address.
                        setIllegal = 1'b1;
                        if (fieldIf.in_last) stateD = ST_DONE;
                    end
                end
            end
            ST_WRITE: begin
                if (lastQ) begin
                    stateD = ST_DONE;
                end else if (imem_addr == LAST_ADDR) begin
                    stateD  = ST_DONE;
                    setFull = 1'b1;
                end else begin
                    stateD = ST_ACCEPT;
                end
            end
            default: stateD = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ      <= ST_IDLE;
            lastQ       <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            count       <= '0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            stateQ  <= stateD;
            imem_we <= (stateD == ST_WRITE);
            done    <= (stateD == ST_DONE);
            if (clearSession) begin
                imem_addr   <= '0;
                count       <= '0;
                err_illegal <= 1'b0;
                err_full    <= 1'b0;
            end else begin
                if (acceptWord) begin
                    imem_wdata <= encWord;
                    lastQ      <= fieldIf.in_last;
                end
                if (stateQ == ST_WRITE) begin
                    imem_addr <= imem_addr + 1'b1;
                    count     <= count + 1'b1;
                end
                if (setIllegal) err_illegal <= 1'b1;
                if (setFull)    err_full    <= 1'b1;
            end
        end
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Sequential instruction encoder and loader for the 16-bit single-cycle CPU. Accepts decoded instruction fields over a valid/ready stream, encodes them into 16-bit instruction words, checks them against the legal opcode set, and writes them into instruction memory at consecutive addresses. It is the inverse of the control decoder: fields go in, instruction words come out. It sits between the testbench or host program source and the instruction memory write port.

## Interface
- ADDR_W, 8: instruction memory address width; capacity DEPTH = 2**ADDR_W words.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a load session at address 0.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader can accept a bundle this cycle.
- in_op  in  4  opcode.
- in_rs, in_rt, in_rd  in  2 each  register fields.
- in_funct  in  2  R-type function field.
- in_imm  in  8  immediate/offset, two's complement.
- in_last  in  1  marks the final instruction of the program.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  16  encoded instruction word.
- count  out  ADDR_W+1  number of words written this session.
- done  out  1  session finished; held until next start.
- err_illegal  out  1  sticky; an illegal opcode was dropped.
- err_full  out  1  sticky; memory filled before in_last.

## Operation
- Encoding, R-type (op 0000, 0001, 0010): {op, rs, rt, rd, 4'b0000, funct}.
- Encoding, I-type (op 1001, 1010, 1011, 1100, 1101, 1110, 1111): {op, rs, rt, imm[7:0]}.
- Illegal opcodes: 0011 through 1000.
- FSM states:
  - IDLE: in_ready=0. start goes to ACCEPT; also clears count, addr, err_illegal, err_full and done.
  - ACCEPT: in_ready=1. On a legal handshake, register the word, go to WRITE. On an illegal handshake, set err_illegal, do not write or advance, stay in ACCEPT; if that bundle has in_last=1, go to DONE.
  - WRITE: imem_we=1 for exactly one cycle with the registered addr and wdata; in_ready=0. On exit, addr+1 and count+1.
    - If the bundle had in_last, go to DONE.
    - Else if the address just written is DEPTH-1, set err_full and go to DONE.
    - Else go to ACCEPT.
  - DONE: done=1, in_ready=0. start goes to ACCEPT with the same clears as IDLE.
- start in ACCEPT or WRITE is ignored.
- in_valid outside ACCEPT is ignored; no bundle is consumed.
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, err_illegal=0, err_full=0, state IDLE.
- Reset asserted mid-session aborts immediately; imem_we drops asynchronously and no partial write is issued.

## Timing
- Handshake occurs on a rising edge with in_valid && in_ready. The write is issued in the following cycle.
- Throughput is one word per 2 cycles; in_ready is low during WRITE.
- imem_addr, imem_wdata and imem_we are all registered outputs.
- count updates on the edge ending WRITE. It equals the number of completed writes; maximum value is DEPTH.
- done rises on the edge ending the final WRITE, or the edge of an illegal in_last handshake.

## Structure
- Shared package cpu16_pkg holds:
  - opcode localparams (OP_LOGIC, OP_ARITH, OP_SHIFT, OP_ADDI, OP_SUBI, OP_SLTI, OP_LW, OP_SW, OP_BNE, OP_BEQ);
  - field bit positions;
  - the loader state enum.
- One combinational sub-module, instr_encode: fields in, 16-bit word plus legal flag out. This module is shared with the future disassembler checker.

## Test plan
- ADD, op 0001, rs=1, rt=2, rd=3, funct=00, in_last=1 → one write, addr 0, wdata 0x16C0; done=1, count=1.
- ADDI (op 1001, rs=0, rt=1, imm=0x05), then LW (op 1100, rs=2, rt=3, imm=0xFC, last) → writes 0x9105 at addr 0 and 0xCBFC at addr 1; count=2.
- Illegal op 0101 sent between two legal bundles → err_illegal=1; only 2 writes, at addrs 0 and 1; no address gap.
- ADDR_W=2, five bundles with no in_last → 4 writes at addrs 0–3; err_full=1, done=1; fifth bundle never accepted (in_ready=0).
- Reset pulse in the cycle imem_we=1 → imem_we=0 immediately; all outputs at reset values; next start writes from addr 0.
- start pulsed in DONE after an error session → err flags and count clear; new session begins at addr 0.
